pcie_intr_mc_ctrl: RTL
======================

// Module: pcie_intr_mc_ctrl
// PURPOSE
//  Multi-source PCIe endpoint interrupt controller; successor to the single-source DMA-done interrupt logic.
//  Latches up to NUM_SRC done events and arbitrates them round-robin onto the core cfg_interrupt handshake.
//  Supports multi-vector MSI (one vector per source, capped by allocated vectors) and legacy INTx assert/deassert.
//  Sits between the DMA engines and the PCIe hard-core cfg interface.
// PARAMETERS
//  NUM_SRC    4   number of interrupt sources (1..8)
//  HOLDOFF_W  16  width of coalescing holdoff counter (used only with PCIE_INTR_COALESCE_EN)
// PORTS
//  clk                       in   1          core user clock
//  rst                       in   1          synchronous active-high reset
//  init_rst_i                in   1          soft init: clear all pending bits
//  src_done_i                in   NUM_SRC    per-source done strobe, sampled every cycle
//  src_en_i                  in   NUM_SRC    per-source enable mask; disabled sources never set pending
//  msi_on                    in   1          1 = MSI mode, 0 = legacy INTx; sampled only in IDLE
//  msi_mmenable_i            in   3          log2 of MSI vectors allocated by host (cfg_interrupt_mmenable)
//  intr_ack_i                in   NUM_SRC    software write-1-to-clear of pending bits
//  holdoff_i                 in   HOLDOFF_W  coalescing gap in clk cycles after each MSI grant
//  cfg_interrupt_n_o         out  1          interrupt request to core, active low
//  cfg_interrupt_rdy_n_i     in   1          core grant, active low
//  cfg_interrupt_assert_n_o  out  1          legacy: 0 = Assert_INTx, 1 = Deassert_INTx message
//  cfg_interrupt_di_o        out  8          MSI vector number
//  cfg_interrupt_legacyclr   in   1          core request to clear legacy interrupt
//  intr_status_o             out  NUM_SRC    current pending bits
// BEHAVIOUR
//  Reset: cfg_interrupt_n_o=1, cfg_interrupt_assert_n_o=1, cfg_interrupt_di_o=0, intr_status_o=0, RR pointer=0, FSM=IDLE.
//  Pending: bit i set when src_done_i[i]&src_en_i[i]; cleared by intr_ack_i[i], init_rst_i, or MSI grant of i.
//   Set and clear in the same cycle: set wins. Pending visible on intr_status_o the cycle after the strobe.
//  FSM states: IDLE, MSI_REQ, LEG_ASSERT, LEG_ACTIVE, LEG_DEASSERT, HOLDOFF.
//  IDLE: if msi_on & |pending -> MSI_REQ; if !msi_on & |pending -> LEG_ASSERT.
//   Latency: strobe at edge T, pending at T+1, cfg_interrupt_n_o low from T+2.
//  MSI_REQ: winner = first pending at/after RR pointer, frozen on entry; cfg_interrupt_n_o=0;
//   cfg_interrupt_di_o = min(winner, 2^msi_mmenable_i - 1).
//   Hold until cfg_interrupt_rdy_n_i=0 sampled; then clear winner's pending, pointer = winner+1 (mod NUM_SRC),
//   cfg_interrupt_n_o=1 next cycle, -> IDLE (or HOLDOFF). Request never withdrawn before grant.
//  LEG_ASSERT: cfg_interrupt_n_o=0, assert_n=0 until grant -> LEG_ACTIVE. Grant does not clear pending.
//  LEG_ACTIVE: cfg_interrupt_n_o=1; when pending==0 or cfg_interrupt_legacyclr=1 -> LEG_DEASSERT.
//   legacyclr also clears all pending bits.
//  LEG_DEASSERT: cfg_interrupt_n_o=0, assert_n=1 until grant -> IDLE (re-asserts if pending re-set).
//  init_rst_i mid-handshake: pending cleared, but the in-flight request holds until grant, then normal exit.
//  rst mid-handshake: immediate return to reset values; no handshake completion.
//  msi_on change while not IDLE: ignored until IDLE.
//  All-vectors case msi_mmenable_i=0: every source maps to vector 0.
// CONFIGURATION
//  PCIE_INTR_COALESCE_EN defined: after each MSI grant enter HOLDOFF, count holdoff_i cycles
//   (value latched at grant), then IDLE; holdoff_i=0 behaves as not defined. Legacy path unaffected.
//  Not defined: no HOLDOFF state, no counter; holdoff_i unused; MSI grant -> IDLE directly.
// STRUCTURE
//  Shared include pcie_intr_defs.vh: FSM state encodings, MAX_SRC=8, vector width constant.
//  Sub-module pcie_intr_rr_arb: combinational round-robin pick of pending vs pointer (index + valid).
//  Top: pending register, FSM, pointer, holdoff counter.
// TESTING
//  MSI single: msi_on=1, mmenable=2, src_done_i=4'b0100 one cycle -> req low 2 cycles later, di=2;
//   rdy_n low 1 cycle -> req high next cycle, status=0.
//  MSI RR: src_done_i=4'b1011 once, rdy_n low 1 cycle per request -> vectors 0,1,3 in order, status drains to 0.
//  Vector cap: mmenable=0, source 3 pending -> di=0; mmenable=1 -> di=1.
//  Legacy: msi_on=0, src 1 done -> assert msg (assert_n=0) granted; intr_ack_i=4'b0010 -> deassert msg (assert_n=1); IDLE.
//  Legacyclr/init: legacy active, legacyclr=1 -> status=0, deassert msg; init_rst_i during MSI_REQ -> req stays low until rdy_n.
//  Coalesce (macro on): holdoff_i=20, two sources pending -> second request starts 22 cycles after first grant; holdoff_i=0 -> 2 cycles.

Source files
------------

// File: rtl/pcie_intr_mc_ctrl_pkg.sv
// Shared types and constants for the multi-source PCIe interrupt controller.
// Optional macro PCIE_INTR_COALESCE_EN adds the MSI holdoff state.
package pcie_intr_mc_ctrl_pkg;

  localparam int MAX_SRC = 8;
  localparam int VEC_W   = 8;
  localparam int IDX_W   = $clog2(MAX_SRC);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_MSI_REQ      = 3'd1,
    ST_LEG_ASSERT   = 3'd2,
    ST_LEG_ACTIVE   = 3'd3,
    ST_LEG_DEASSERT = 3'd4
`ifdef PCIE_INTR_COALESCE_EN
    ,
    ST_HOLDOFF      = 3'd5
`endif
  } st_e;

  // Source index mapped onto the allocated MSI vector range.
  function automatic logic [VEC_W-1:0] vec_cap(
    input logic [IDX_W-1:0] win,
    input logic [2:0]       mmen
  );
    logic [VEC_W-1:0] lim;
    logic [VEC_W-1:0] w;
    lim = (VEC_W'(1) << mmen) - VEC_W'(1);
    w   = {{(VEC_W-IDX_W){1'b0}}, win};
    return (w > lim) ? lim : w;
  endfunction

endpackage

// File: rtl/pcie_intr_rr_arb.sv
// Round-robin pick of the first pending source at or after the pointer.
// Purely combinational; returns index and valid.
module pcie_intr_rr_arb
  import pcie_intr_mc_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]   i_pend,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_vld
);

  logic [2*NUM_SRC-1:0] w_rot;
  logic [IDX_W:0]       w_sum;

  assign w_rot = {i_pend, i_pend} >> i_ptr;

  // Scan downwards so the nearest slot after the pointer wins last.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_sum = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
        if (w_sum >= (IDX_W+1)'(NUM_SRC))
          w_sum = w_sum - (IDX_W+1)'(NUM_SRC);
        o_vld = 1'b1;
        o_idx = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_intr_mc_ctrl.sv
// Multi-source MSI / legacy INTx interrupt controller for a PCIe endpoint.
// Define PCIE_INTR_COALESCE_EN to enable the post-grant MSI holdoff.
module pcie_intr_mc_ctrl
  import pcie_intr_mc_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_rst_i,
  input  logic [NUM_SRC-1:0]   src_done_i,
  input  logic [NUM_SRC-1:0]   src_en_i,
  input  logic                 msi_on,
  input  logic [2:0]           msi_mmenable_i,
  input  logic [NUM_SRC-1:0]   intr_ack_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic                 cfg_interrupt_n_o,
  input  logic                 cfg_interrupt_rdy_n_i,
  output logic                 cfg_interrupt_assert_n_o,
  output logic [VEC_W-1:0]     cfg_interrupt_di_o,
  input  logic                 cfg_interrupt_legacyclr,
  output logic [NUM_SRC-1:0]   intr_status_o
);

  st_e                  r_state;
  st_e                  w_nxt;
  logic [NUM_SRC-1:0]   r_pend;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_win;
  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_vld;
  logic                 w_grant;
  logic                 w_msi_done;
  logic                 w_legclr;
  logic [NUM_SRC-1:0]   w_win_oh;
  logic [NUM_SRC-1:0]   w_clr;

  pcie_intr_rr_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .i_pend (r_pend),
    .i_ptr  (r_ptr),
    .o_idx  (w_arb_idx),
    .o_vld  (w_arb_vld)
  );

  assign w_grant    = ~cfg_interrupt_rdy_n_i;
  assign w_msi_done = (r_state == ST_MSI_REQ) & w_grant;
  assign w_legclr   = (r_state == ST_LEG_ACTIVE) & cfg_interrupt_legacyclr;
  assign w_win_oh   = NUM_SRC'(1) << r_win;
  assign w_clr      = intr_ack_i
                    | {NUM_SRC{init_rst_i | w_legclr}}
                    | (w_msi_done ? w_win_oh : '0);
  assign intr_status_o = r_pend;

`ifdef PCIE_INTR_COALESCE_EN
  logic [HOLDOFF_W-1:0] r_cnt;

  // Holdoff counter: latched at MSI grant, counts down in HOLDOFF.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_msi_done)
      r_cnt <= holdoff_i;
    else if (r_state == ST_HOLDOFF)
      r_cnt <= r_cnt - HOLDOFF_W'(1);
  end
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = ^holdoff_i;
`endif

  // Pending bits: a new strobe beats any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)
      r_pend <= '0;
    else
      r_pend <= (r_pend & ~w_clr) | (src_done_i & src_en_i);
  end

  // Winner is frozen on MSI entry; pointer advances past it on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= '0;
      r_ptr <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (w_nxt == ST_MSI_REQ))
        r_win <= w_arb_idx;
      if (w_msi_done)
        r_ptr <= (r_win == IDX_W'(NUM_SRC - 1)) ? '0
                                                : r_win + IDX_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_nxt                    = r_state;
    cfg_interrupt_n_o        = 1'b1;
    cfg_interrupt_assert_n_o = 1'b1;
    cfg_interrupt_di_o       = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_vld)
          w_nxt = msi_on ? ST_MSI_REQ : ST_LEG_ASSERT;
      end
      ST_MSI_REQ: begin
        cfg_interrupt_n_o  = 1'b0;
        cfg_interrupt_di_o = vec_cap(r_win, msi_mmenable_i);
        if (w_grant) begin
`ifdef PCIE_INTR_COALESCE_EN
          w_nxt = (holdoff_i != '0) ? ST_HOLDOFF : ST_IDLE;
`else
          w_nxt = ST_IDLE;
`endif
        end
      end
      ST_LEG_ASSERT: begin
        cfg_interrupt_n_o        = 1'b0;
        cfg_interrupt_assert_n_o = 1'b0;
        if (w_grant)
          w_nxt = ST_LEG_ACTIVE;
      end
      ST_LEG_ACTIVE: begin
        if ((r_pend == '0) || cfg_interrupt_legacyclr)
          w_nxt = ST_LEG_DEASSERT;
      end
      ST_LEG_DEASSERT: begin
        cfg_interrupt_n_o = 1'b0;
        if (w_grant)
          w_nxt = ST_IDLE;
      end
`ifdef PCIE_INTR_COALESCE_EN
      ST_HOLDOFF: begin
        if (r_cnt <= HOLDOFF_W'(1))
          w_nxt = ST_IDLE;
      end
`endif
      default: w_nxt = ST_IDLE;
    endcase
  end

endmodule
